mem_handle_arb: RTL and testbench

MEM_HANDLE_ARB -- requirements
Module: mem_handle_arb

---
 rtl/mem_handle_arb.sv | 217 +++++++++++++++++++++
 tb/tb_mem_handle_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_handle_arb.sv
// Round-robin arbiter sharing one memory port among NUM_CH region-walking client handles.
// Optional macro MEM_HANDLE_WRAP_EN: reload ptr at region end (ch_done pulses) instead of parking with ch_done held.
module mem_handle_arb #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH*ADDR_W-1:0] ch_region_begin,
  input  logic [NUM_CH*ADDR_W-1:0] ch_region_end,
  input  logic [NUM_CH-1:0]        ch_w_en,
  input  logic [NUM_CH-1:0]        ch_r_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH*ADDR_W-1:0] ch_ptr,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_avail,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [ADDR_W-1:0] begin_q [NUM_CH];
  logic [ADDR_W-1:0] begin_d [NUM_CH];
  logic [ADDR_W-1:0] end_q   [NUM_CH];
  logic [ADDR_W-1:0] end_d   [NUM_CH];
  logic [ADDR_W-1:0] ptr_q   [NUM_CH];
  logic [ADDR_W-1:0] ptr_d   [NUM_CH];
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] done_pulse_q, done_pulse_d;
  logic [NUM_CH-1:0] avail_q, avail_d;
  logic              stale_q, stale_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] pend_s;
  logic              found_s;
  logic [IDX_W-1:0]  pick_s;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    return IDX_W'((sum >= NUM_CH) ? (sum - NUM_CH) : sum);
  endfunction

  // Next-state logic: channel bookkeeping, round-robin pick and the IDLE/BUSY request FSM
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    active_d     = active_q;
    done_d       = done_q;
    done_pulse_d = {NUM_CH{1'b0}};
    avail_d      = {NUM_CH{1'b0}};
    stale_d      = stale_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    pend_s       = {NUM_CH{1'b0}};
    found_s      = 1'b0;
    pick_s       = {IDX_W{1'b0}};

    // ch_start lands before arbitration so a same-cycle grant already sees the new region
    for (int c = 0; c < NUM_CH; c++) begin
      begin_d[c] = begin_q[c];
      end_d[c]   = end_q[c];
      ptr_d[c]   = ptr_q[c];
      if (ch_start[c]) begin
        begin_d[c]  = ch_region_begin[c*ADDR_W +: ADDR_W];
        end_d[c]    = ch_region_end[c*ADDR_W +: ADDR_W];
        ptr_d[c]    = ch_region_begin[c*ADDR_W +: ADDR_W];
        active_d[c] = 1'b1;
        done_d[c]   = (ch_region_begin[c*ADDR_W +: ADDR_W] > ch_region_end[c*ADDR_W +: ADDR_W]);
      end else begin
        active_d[c] = active_q[c];
      end
      pend_s[c] = active_d[c] & ~done_d[c] & (ch_w_en[c] | ch_r_en[c]);
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (!found_s && pend_s[rr_index(rr_q, i)]) begin
        found_s = 1'b1;
        pick_s  = rr_index(rr_q, i);
      end else begin
        found_s = found_s;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d     = ST_BUSY;
          grant_d     = pick_s;
          rr_d        = (pick_s == IDX_W'(NUM_CH - 1)) ? {IDX_W{1'b0}} : (pick_s + 1'b1);
          mem_req_d   = 1'b1;
          mem_we_d    = ch_w_en[pick_s];
          mem_addr_d  = ptr_d[pick_s];
          mem_wdata_d = ch_wdata[int'(pick_s)*DATA_W +: DATA_W];
          stale_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d          = ST_IDLE;
          mem_req_d        = 1'b0;
          mem_we_d         = 1'b0;
          avail_d[grant_q] = 1'b1;
          stale_d          = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          // a restart of this channel while in flight voids this access's ptr/done update
          if (!stale_q && !ch_start[grant_q]) begin
            if (ptr_q[grant_q] == end_q[grant_q]) begin
`ifdef MEM_HANDLE_WRAP_EN
              ptr_d[grant_q]        = begin_q[grant_q];
              done_pulse_d[grant_q] = 1'b1;
`else
              done_d[grant_q]       = 1'b1;
`endif
            end else begin
              ptr_d[grant_q] = ptr_q[grant_q] + 1'b1;
            end
          end else begin
            stale_d = 1'b0;
          end
        end else begin
          stale_d = stale_q | ch_start[grant_q];
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; reset clears every output-facing flop immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= {IDX_W{1'b0}};
      rr_q         <= {IDX_W{1'b0}};
      active_q     <= {NUM_CH{1'b0}};
      done_q       <= {NUM_CH{1'b0}};
      done_pulse_q <= {NUM_CH{1'b0}};
      avail_q      <= {NUM_CH{1'b0}};
      stale_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
        begin_q[c] <= {ADDR_W{1'b0}};
        end_q[c]   <= {ADDR_W{1'b0}};
        ptr_q[c]   <= {ADDR_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      active_q     <= active_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      avail_q      <= avail_d;
      stale_q      <= stale_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      for (int c = 0; c < NUM_CH; c++) begin
        begin_q[c] <= begin_d[c];
        end_q[c]   <= end_d[c];
        ptr_q[c]   <= ptr_d[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ptr_out
    assign ch_ptr[g*ADDR_W +: ADDR_W] = ptr_q[g];
  end

  assign ch_rdata  = rdata_q;
  assign ch_avail  = avail_q;
  assign ch_done   = done_q | done_pulse_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_handle_arb.sv
// Directed self-checking bench for mem_handle_arb (default parameters); the bench plays the memory side.
`timescale 1ns/1ps
module tb_mem_handle_arb;

  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int NCH = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [NCH-1:0]     ch_start;
  logic [NCH*AW-1:0]  ch_region_begin;
  logic [NCH*AW-1:0]  ch_region_end;
  logic [NCH-1:0]     ch_w_en;
  logic [NCH-1:0]     ch_r_en;
  logic [NCH*DW-1:0]  ch_wdata;
  logic [NCH*AW-1:0]  ch_ptr;
  logic [DW-1:0]      ch_rdata;
  logic [NCH-1:0]     ch_avail;
  logic [NCH-1:0]     ch_done;
  logic               mem_req;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_ack;
  logic [DW-1:0]      mem_rdata;

  int checks = 0;
  int fails  = 0;

  mem_handle_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NCH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ch_start       (ch_start),
    .ch_region_begin(ch_region_begin),
    .ch_region_end  (ch_region_end),
    .ch_w_en        (ch_w_en),
    .ch_r_en        (ch_r_en),
    .ch_wdata       (ch_wdata),
    .ch_ptr         (ch_ptr),
    .ch_rdata       (ch_rdata),
    .ch_avail       (ch_avail),
    .ch_done        (ch_done),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Load a region and pulse ch_start for one clock (driven on the falling edge).
  task automatic pulse_start(input int c, input logic [AW-1:0] b, input logic [AW-1:0] e);
    ch_region_begin[c*AW +: AW] = b;
    ch_region_end[c*AW +: AW]   = e;
    ch_start[c] = 1'b1;
    @(negedge clock);
    ch_start[c] = 1'b0;
  endtask

  // Bounded wait for mem_req, checked on falling edges.
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        if (mem_req === 1'b1) seen = 1'b1;
        else @(negedge clock);
      end
    end
  endtask

  // Hold off delay cycles (tracking request stability), then ack for one cycle.
  task automatic ack_after(input int delay, input logic [DW-1:0] rd, output bit stable);
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    a = mem_addr;
    w = mem_we;
    d = mem_wdata;
    stable = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      if (mem_req !== 1'b1 || mem_addr !== a || mem_we !== w || mem_wdata !== d) stable = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_0000;
  endtask

  task automatic watch_idle(input int n, output bit saw_req, output bit saw_avail);
    saw_req   = 1'b0;
    saw_avail = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (mem_req === 1'b1) saw_req = 1'b1;
      if (ch_avail !== 4'b0000) saw_avail = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 23'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (ch_ptr !== 92'h0) begin fails++; $display("FAIL reset_ch_ptr: got %h expected 0", ch_ptr); end
    checks++; if (ch_done !== 4'b0000 || ch_avail !== 4'b0000) begin fails++; $display("FAIL reset_flags: got done=%b avail=%b expected 0", ch_done, ch_avail); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr  [5] = '{23'h100, 23'h110, 23'h120, 23'h130, 23'h101};
    logic [NCH-1:0] exp_av   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bit seen, stable;
    for (int c = 0; c < NCH; c++) begin
      ch_region_begin[c*AW +: AW] = AW'(32'h100 + 32'h10 * c);
      ch_region_end[c*AW +: AW]   = AW'(32'h10F + 32'h10 * c);
    end
    ch_r_en  = 4'b1111;
    ch_start = 4'b1111;
    @(negedge clock);
    ch_start = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      wait_req(seen);
      checks++; if (!seen) begin fails++; $display("FAIL rr_req_timeout: access %0d got none expected mem_req", k); end
      checks++; if (mem_addr !== exp_addr[k]) begin fails++; $display("FAIL rr_addr: access %0d got %h expected %h", k, mem_addr, exp_addr[k]); end
      ack_after(0, 32'h0000_1000 + k, stable);
      if (k == 4) ch_r_en = 4'b0000;
      checks++; if (ch_avail !== exp_av[k]) begin fails++; $display("FAIL rr_avail: access %0d got %b expected %b", k, ch_avail, exp_av[k]); end
    end
  endtask

  task automatic test_single_channel();
    logic [AW-1:0] exp_addr [3] = '{23'h10, 23'h11, 23'h12};
    logic [DW-1:0] exp_rd   [3] = '{32'hA000_0010, 32'hA000_0011, 32'hA000_0012};
    logic [AW-1:0] exp_ptr  [2] = '{23'h11, 23'h12};
    bit seen, stable, saw_req, saw_av;
    ch_r_en[0] = 1'b1;
    pulse_start(0, 23'h10, 23'h12);
    for (int k = 0; k < 3; k++) begin
      wait_req(seen);
      checks++; if (!seen) begin fails++; $display("FAIL single_req_timeout: access %0d got none expected mem_req", k); end
      checks++; if (mem_addr !== exp_addr[k] || mem_we !== 1'b0) begin fails++; $display("FAIL single_addr: access %0d got %h we=%b expected %h we=0", k, mem_addr, mem_we, exp_addr[k]); end
      ack_after(1, exp_rd[k], stable);
      if (k == 2) ch_r_en[0] = 1'b0;
      checks++; if (ch_avail !== 4'b0001) begin fails++; $display("FAIL single_avail: access %0d got %b expected 0001", k, ch_avail); end
      checks++; if (ch_rdata !== exp_rd[k]) begin fails++; $display("FAIL single_rdata: access %0d got %h expected %h", k, ch_rdata, exp_rd[k]); end
      if (k < 2) begin
        checks++; if (ch_ptr[0 +: AW] !== exp_ptr[k]) begin fails++; $display("FAIL single_ptr: access %0d got %h expected %h", k, ch_ptr[0 +: AW], exp_ptr[k]); end
      end
    end
    checks++; if (ch_done[0] !== 1'b1) begin fails++; $display("FAIL single_done: got %b expected 1", ch_done[0]); end
`ifdef MEM_HANDLE_WRAP_EN
    checks++; if (ch_ptr[0 +: AW] !== 23'h10) begin fails++; $display("FAIL single_end_ptr: got %h expected 10", ch_ptr[0 +: AW]); end
`else
    checks++; if (ch_ptr[0 +: AW] !== 23'h12) begin fails++; $display("FAIL single_end_ptr: got %h expected 12", ch_ptr[0 +: AW]); end
`endif
    watch_idle(5, saw_req, saw_av);
    checks++; if (saw_req || saw_av) begin fails++; $display("FAIL single_extra_access: got req=%b avail=%b expected 0", saw_req, saw_av); end
  endtask

  task automatic test_write_priority();
    bit seen, stable;
    ch_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
    ch_w_en[1] = 1'b1;
    ch_r_en[1] = 1'b1;
    pulse_start(1, 23'h200, 23'h20F);
    wait_req(seen);
    checks++; if (!seen) begin fails++; $display("FAIL wr_req_timeout: got none expected mem_req"); end
    checks++; if (mem_addr !== 23'h200 || mem_we !== 1'b1) begin fails++; $display("FAIL wr_req: got addr=%h we=%b expected 200 we=1", mem_addr, mem_we); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_wdata: got %h expected deadbeef", mem_wdata); end
    ack_after(3, 32'h0000_0000, stable);
    ch_w_en[1] = 1'b0;
    ch_r_en[1] = 1'b0;
    checks++; if (stable !== 1'b1) begin fails++; $display("FAIL wr_hold: got stable=%b expected 1", stable); end
    checks++; if (ch_avail !== 4'b0010) begin fails++; $display("FAIL wr_avail: got %b expected 0010", ch_avail); end
    checks++; if (ch_ptr[1*AW +: AW] !== 23'h201) begin fails++; $display("FAIL wr_ptr: got %h expected 201", ch_ptr[1*AW +: AW]); end
  endtask

  task automatic test_restart_mid_access();
    bit seen, stable;
    ch_r_en[2] = 1'b1;
    pulse_start(2, 23'h05, 23'h0F);
    wait_req(seen);
    checks++; if (!seen || mem_addr !== 23'h05) begin fails++; $display("FAIL rst_first: got seen=%b addr=%h expected 05", seen, mem_addr); end
    pulse_start(2, 23'h40, 23'h4F);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 23'h05) begin fails++; $display("FAIL rst_inflight: got req=%b addr=%h expected 1/05", mem_req, mem_addr); end
    ack_after(0, 32'h5555_0005, stable);
    checks++; if (ch_avail !== 4'b0100 || ch_rdata !== 32'h5555_0005) begin fails++; $display("FAIL rst_avail: got %b/%h expected 0100/55550005", ch_avail, ch_rdata); end
    checks++; if (ch_ptr[2*AW +: AW] !== 23'h40) begin fails++; $display("FAIL rst_ptr: got %h expected 40", ch_ptr[2*AW +: AW]); end
    wait_req(seen);
    checks++; if (!seen || mem_addr !== 23'h40) begin fails++; $display("FAIL rst_next: got seen=%b addr=%h expected 40", seen, mem_addr); end
    ack_after(0, 32'h5555_0040, stable);
    ch_r_en[2] = 1'b0;
    checks++; if (ch_ptr[2*AW +: AW] !== 23'h41) begin fails++; $display("FAIL rst_ptr_inc: got %h expected 41", ch_ptr[2*AW +: AW]); end
  endtask

  task automatic test_empty_region();
    bit saw_req, saw_av;
    ch_r_en[3] = 1'b1;
    pulse_start(3, 23'h50, 23'h4F);
    checks++; if (ch_done[3] !== 1'b1) begin fails++; $display("FAIL empty_done: got %b expected 1", ch_done[3]); end
    watch_idle(5, saw_req, saw_av);
    checks++; if (saw_req || saw_av) begin fails++; $display("FAIL empty_access: got req=%b avail=%b expected 0", saw_req, saw_av); end
    ch_r_en[3] = 1'b0;
  endtask

  task automatic test_top_address();
    bit seen, stable, saw_req, saw_av;
    ch_r_en[0] = 1'b1;
    pulse_start(0, 23'h7FFFFF, 23'h7FFFFF);
`ifdef MEM_HANDLE_WRAP_EN
    for (int k = 0; k < 2; k++) begin
      wait_req(seen);
      checks++; if (!seen || mem_addr !== 23'h7FFFFF) begin fails++; $display("FAIL top_addr: access %0d got seen=%b addr=%h expected 7fffff", k, seen, mem_addr); end
      if (k == 1) begin
        checks++; if (ch_done[0] !== 1'b0) begin fails++; $display("FAIL top_done_clear: got %b expected 0", ch_done[0]); end
      end
      ack_after(1, 32'h7777_0000 + k, stable);
      if (k == 1) ch_r_en[0] = 1'b0;
      checks++; if (ch_avail !== 4'b0001 || ch_done[0] !== 1'b1) begin fails++; $display("FAIL top_pulse: access %0d got avail=%b done=%b expected 0001/1", k, ch_avail, ch_done[0]); end
      checks++; if (ch_ptr[0 +: AW] !== 23'h7FFFFF) begin fails++; $display("FAIL top_ptr: access %0d got %h expected 7fffff", k, ch_ptr[0 +: AW]); end
    end
`else
    wait_req(seen);
    checks++; if (!seen || mem_addr !== 23'h7FFFFF) begin fails++; $display("FAIL top_addr: got seen=%b addr=%h expected 7fffff", seen, mem_addr); end
    ack_after(1, 32'h7777_0000, stable);
    checks++; if (ch_avail !== 4'b0001 || ch_done[0] !== 1'b1) begin fails++; $display("FAIL top_done: got avail=%b done=%b expected 0001/1", ch_avail, ch_done[0]); end
    checks++; if (ch_ptr[0 +: AW] !== 23'h7FFFFF) begin fails++; $display("FAIL top_ptr: got %h expected 7fffff", ch_ptr[0 +: AW]); end
    watch_idle(5, saw_req, saw_av);
    checks++; if (saw_req || ch_done[0] !== 1'b1) begin fails++; $display("FAIL top_hold: got req=%b done=%b expected 0/1", saw_req, ch_done[0]); end
    ch_r_en[0] = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_access();
    bit seen, saw_req, saw_av;
    ch_r_en[1] = 1'b1;
    pulse_start(1, 23'h300, 23'h30F);
    wait_req(seen);
    checks++; if (!seen || mem_addr !== 23'h300) begin fails++; $display("FAIL mrst_req: got seen=%b addr=%h expected 300", seen, mem_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 23'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL mrst_mem: got req=%b addr=%h wdata=%h expected 0", mem_req, mem_addr, mem_wdata); end
    checks++; if (ch_ptr !== 92'h0 || ch_done !== 4'b0000 || ch_rdata !== 32'h0) begin fails++; $display("FAIL mrst_ch: got ptr=%h done=%b rdata=%h expected 0", ch_ptr, ch_done, ch_rdata); end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0000_0000;
    checks++; if (ch_avail !== 4'b0000 || ch_rdata !== 32'h0) begin fails++; $display("FAIL mrst_late_ack: got avail=%b rdata=%h expected 0", ch_avail, ch_rdata); end
    watch_idle(5, saw_req, saw_av);
    checks++; if (saw_req || saw_av) begin fails++; $display("FAIL mrst_inactive: got req=%b avail=%b expected 0", saw_req, saw_av); end
    ch_r_en[1] = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    ch_start        = 4'b0000;
    ch_region_begin = 92'h0;
    ch_region_end   = 92'h0;
    ch_w_en         = 4'b0000;
    ch_r_en         = 4'b0000;
    ch_wdata        = 128'h0;
    mem_ack         = 1'b0;
    mem_rdata       = 32'h0000_0000;
    test_reset();
    test_round_robin();
    test_single_channel();
    test_write_priority();
    test_restart_mid_access();
    test_empty_region();
    test_top_address();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
